// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: valid/stall/flush handling plus sub-word load
// extraction for writeback. Optional retire counter under MEM_WB_RETIRE_CNT_EN.
module mem_wb_stage #(
  parameter int DATA_WIDTH       = 32,
  parameter int REG_ADDR_WIDTH   = 4,
  parameter int RETIRE_CNT_WIDTH = 32
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        stall,
  input  logic                        flush,
  input  logic                        valid_in,
  input  logic [DATA_WIDTH-1:0]       DataOutDataMemory_in,
  input  logic [DATA_WIDTH-1:0]       ALUResult_in,
  input  logic                        memToReg_in,
  input  logic [1:0]                  loadSize_in,
  input  logic                        loadSigned_in,
  input  logic [REG_ADDR_WIDTH-1:0]   registerFileWrite_in,
  input  logic                        regWrite_in,
  output logic                        valid,
  output logic [DATA_WIDTH-1:0]       DataOutDataMemory,
  output logic [DATA_WIDTH-1:0]       ALUResult,
  output logic                        memToReg,
  output logic [REG_ADDR_WIDTH-1:0]   registerFileWrite,
  output logic                        regWrite,
  output logic [DATA_WIDTH-1:0]       writeBackData,
  output logic                        regWriteEnable,
  output logic [RETIRE_CNT_WIDTH-1:0] retireCount
);

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;

  logic                      valid_q,      valid_d;
  logic [DATA_WIDTH-1:0]     mem_data_q,   mem_data_d;
  logic [DATA_WIDTH-1:0]     alu_result_q, alu_result_d;
  logic                      mem_to_reg_q, mem_to_reg_d;
  logic [1:0]                load_size_q,  load_size_d;
  logic                      load_signed_q, load_signed_d;
  logic [REG_ADDR_WIDTH-1:0] rf_write_q,   rf_write_d;
  logic                      reg_write_q,  reg_write_d;
  logic                      load_en;

  // valid marks a real instruction in the stage; stall holds every field,
  // flush replaces the contents with an all-zero bubble and beats stall.
  assign load_en = !flush && !stall;

  always_comb begin
    valid_d       = valid_q;
    mem_data_d    = mem_data_q;
    alu_result_d  = alu_result_q;
    mem_to_reg_d  = mem_to_reg_q;
    load_size_d   = load_size_q;
    load_signed_d = load_signed_q;
    rf_write_d    = rf_write_q;
    reg_write_d   = reg_write_q;
    if (flush) begin
      valid_d       = 1'b0;
      mem_data_d    = '0;
      alu_result_d  = '0;
      mem_to_reg_d  = 1'b0;
      load_size_d   = 2'd0;
      load_signed_d = 1'b0;
      rf_write_d    = '0;
      reg_write_d   = 1'b0;
    end else if (!stall) begin
      valid_d       = valid_in;
      mem_data_d    = DataOutDataMemory_in;
      alu_result_d  = ALUResult_in;
      mem_to_reg_d  = memToReg_in;
      load_size_d   = loadSize_in;
      load_signed_d = loadSigned_in;
      rf_write_d    = registerFileWrite_in;
      reg_write_d   = regWrite_in;
    end
  end

  always_ff @(negedge clock) begin
    if (reset) begin
      valid_q       <= 1'b0;
      mem_data_q    <= '0;
      alu_result_q  <= '0;
      mem_to_reg_q  <= 1'b0;
      load_size_q   <= 2'd0;
      load_signed_q <= 1'b0;
      rf_write_q    <= '0;
      reg_write_q   <= 1'b0;
    end else begin
      valid_q       <= valid_d;
      mem_data_q    <= mem_data_d;
      alu_result_q  <= alu_result_d;
      mem_to_reg_q  <= mem_to_reg_d;
      load_size_q   <= load_size_d;
      load_signed_q <= load_signed_d;
      rf_write_q    <= rf_write_d;
      reg_write_q   <= reg_write_d;
    end
  end

  assign valid             = valid_q;
  assign DataOutDataMemory = mem_data_q;
  assign ALUResult         = alu_result_q;
  assign memToReg          = mem_to_reg_q;
  assign registerFileWrite = rf_write_q;
  assign regWrite          = reg_write_q;
  assign regWriteEnable    = reg_write_q & valid_q;

  // Sub-word lanes always come from the low 32 bits of the memory word.
  logic [31:0] mem_lo32;
  generate
    if (DATA_WIDTH >= 32) begin : g_lo32_wide
      assign mem_lo32 = mem_data_q[31:0];
    end else begin : g_lo32_narrow
      assign mem_lo32 = {{(32-DATA_WIDTH){1'b0}}, mem_data_q};
    end
  endgenerate

  logic [1:0]             byte_off;
  logic [7:0]             byte_lane;
  logic [15:0]            half_lane;
  logic [DATA_WIDTH+7:0]  byte_ext;
  logic [DATA_WIDTH+15:0] half_ext;

  assign byte_off = alu_result_q[1:0];

  always_comb begin
    byte_lane = 8'(mem_lo32 >> {byte_off, 3'b000});
    half_lane = byte_off[1] ? mem_lo32[31:16] : mem_lo32[15:0];
    byte_ext  = {{DATA_WIDTH{load_signed_q & byte_lane[7]}}, byte_lane};
    half_ext  = {{DATA_WIDTH{load_signed_q & half_lane[15]}}, half_lane};
    writeBackData = alu_result_q;
    if (mem_to_reg_q) begin
      case (load_size_q)
        SIZE_BYTE: writeBackData = byte_ext[DATA_WIDTH-1:0];
        SIZE_HALF: writeBackData = half_ext[DATA_WIDTH-1:0];
        default:   writeBackData = mem_data_q;
      endcase
    end
  end

`ifdef MEM_WB_RETIRE_CNT_EN
  logic [RETIRE_CNT_WIDTH-1:0] retire_cnt_q, retire_cnt_d;

  always_comb begin
    retire_cnt_d = retire_cnt_q;
    if (load_en && valid_in) begin
      retire_cnt_d = retire_cnt_q + RETIRE_CNT_WIDTH'(1);
    end
  end

  always_ff @(negedge clock) begin
    if (reset) begin
      retire_cnt_q <= '0;
    end else begin
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign retireCount = retire_cnt_q;
`else
  assign retireCount = '0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: vector table for single-cycle loads plus
// hand-written reset, stall, flush and retire-counter sequences.
module tb_mem_wb_stage;

  localparam int DW  = 32;
  localparam int AW  = 4;
  localparam int RCW = 4;

  logic           clock = 1'b1;
  logic           reset, stall, flush, valid_in;
  logic [DW-1:0]  mem_in, alu_in;
  logic           m2r_in;
  logic [1:0]     lsize_in;
  logic           lsigned_in;
  logic [AW-1:0]  rfw_in;
  logic           rw_in;

  logic           valid;
  logic [DW-1:0]  mem_out, alu_out, wb_data;
  logic           m2r_out;
  logic [AW-1:0]  rfw_out;
  logic           rw_out, rwe;
  logic [RCW-1:0] retire_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  mem_wb_stage #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .RETIRE_CNT_WIDTH(RCW)) dut (
    .clock(clock), .reset(reset), .stall(stall), .flush(flush), .valid_in(valid_in),
    .DataOutDataMemory_in(mem_in), .ALUResult_in(alu_in), .memToReg_in(m2r_in),
    .loadSize_in(lsize_in), .loadSigned_in(lsigned_in),
    .registerFileWrite_in(rfw_in), .regWrite_in(rw_in),
    .valid(valid), .DataOutDataMemory(mem_out), .ALUResult(alu_out),
    .memToReg(m2r_out), .registerFileWrite(rfw_out), .regWrite(rw_out),
    .writeBackData(wb_data), .regWriteEnable(rwe), .retireCount(retire_cnt)
  );

  // clock / reset block
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic          valid_in;
    logic [31:0]   mem;
    logic [31:0]   alu;
    logic          m2r;
    logic [1:0]    lsize;
    logic          lsigned;
    logic [3:0]    rfw;
    logic          rw;
    logic [31:0]   exp_wb;
    logic          exp_rwe;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: act=0x%08h req=0x%08h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive_vec(input vec_t v);
    valid_in   = v.valid_in;
    mem_in     = v.mem;
    alu_in     = v.alu;
    m2r_in     = v.m2r;
    lsize_in   = v.lsize;
    lsigned_in = v.lsigned;
    rfw_in     = v.rfw;
    rw_in      = v.rw;
  endtask

  task automatic drive_random;
    valid_in   = 1'($urandom_range(1, 0));
    mem_in     = $urandom;
    alu_in     = $urandom;
    m2r_in     = 1'($urandom_range(1, 0));
    lsize_in   = 2'($urandom_range(3, 0));
    lsigned_in = 1'($urandom_range(1, 0));
    rfw_in     = 4'($urandom_range(15, 0));
    rw_in      = 1'b1;
  endtask

  task automatic tick;
    @(negedge clock);
    #1;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_valid"}, 32'(valid), 32'd0);
    check({tag, "_mem"},   mem_out, 32'd0);
    check({tag, "_alu"},   alu_out, 32'd0);
    check({tag, "_m2r"},   32'(m2r_out), 32'd0);
    check({tag, "_rfw"},   32'(rfw_out), 32'd0);
    check({tag, "_rw"},    32'(rw_out), 32'd0);
    check({tag, "_wb"},    wb_data, 32'd0);
    check({tag, "_rwe"},   32'(rwe), 32'd0);
  endtask

  vec_t a, b;
  int   ops[24];
  int   exp_retire;

  initial begin
    vecs[0]  = '{1'b1, 32'h0000_0000, 32'h0000_1234, 1'b0, 2'd2, 1'b0, 4'd5,  1'b1, 32'h0000_1234, 1'b1};
    vecs[1]  = '{1'b1, 32'h80FF_7F81, 32'h0000_0003, 1'b1, 2'd0, 1'b1, 4'd6,  1'b1, 32'hFFFF_FF80, 1'b1};
    vecs[2]  = '{1'b1, 32'h80FF_7F81, 32'h0000_0000, 1'b1, 2'd0, 1'b0, 4'd7,  1'b1, 32'h0000_0081, 1'b1};
    vecs[3]  = '{1'b1, 32'h80FF_7F81, 32'h0000_0002, 1'b1, 2'd1, 1'b1, 4'd8,  1'b1, 32'hFFFF_80FF, 1'b1};
    vecs[4]  = '{1'b1, 32'h80FF_7F81, 32'h0000_0001, 1'b1, 2'd1, 1'b0, 4'd9,  1'b1, 32'h0000_7F81, 1'b1};
    vecs[5]  = '{1'b1, 32'h80FF_7F81, 32'h0000_0001, 1'b1, 2'd0, 1'b1, 4'd10, 1'b1, 32'h0000_007F, 1'b1};
    vecs[6]  = '{1'b1, 32'h80FF_7F81, 32'h0000_0002, 1'b1, 2'd0, 1'b1, 4'd11, 1'b1, 32'hFFFF_FFFF, 1'b1};
    vecs[7]  = '{1'b1, 32'h80FF_7F81, 32'h0000_0002, 1'b1, 2'd0, 1'b0, 4'd12, 1'b0, 32'h0000_00FF, 1'b0};
    vecs[8]  = '{1'b1, 32'h80FF_7F81, 32'h0000_0000, 1'b1, 2'd1, 1'b1, 4'd13, 1'b1, 32'h0000_7F81, 1'b1};
    vecs[9]  = '{1'b1, 32'h80FF_7F81, 32'h0000_0003, 1'b1, 2'd1, 1'b0, 4'd14, 1'b1, 32'h0000_80FF, 1'b1};
    vecs[10] = '{1'b1, 32'h80FF_7F81, 32'h0000_0003, 1'b1, 2'd2, 1'b1, 4'd15, 1'b1, 32'h80FF_7F81, 1'b1};
    vecs[11] = '{1'b1, 32'h80FF_7F81, 32'h0000_0001, 1'b1, 2'd3, 1'b1, 4'd1,  1'b1, 32'h80FF_7F81, 1'b1};
    vecs[12] = '{1'b0, 32'h1234_5678, 32'h0000_DEAD, 1'b0, 2'd0, 1'b0, 4'd2,  1'b1, 32'h0000_DEAD, 1'b0};
    vecs[13] = '{1'b1, 32'h0000_0000, 32'hCAFE_F00D, 1'b0, 2'd0, 1'b1, 4'd0,  1'b1, 32'hCAFE_F00D, 1'b1};

    stall = 1'b0; flush = 1'b0; reset = 1'b1;
    drive_random();

    // Reset for two edges with random inputs.
    for (int i = 0; i < 2; i++) begin
      drive_random();
      tick();
      check_cleared($sformatf("reset%0d", i));
      check($sformatf("reset%0d_retire", i), 32'(retire_cnt), 32'd0);
    end
    reset = 1'b0;
    drive_vec(vecs[0]);
    tick();
    check("post_reset_wb", wb_data, 32'h0000_1234);
    check("post_reset_rwe", 32'(rwe), 32'd1);

    // Table vectors.
    for (int i = 0; i < 14; i++) begin
      drive_vec(vecs[i]);
      tick();
      check($sformatf("v%0d_wb", i),    wb_data, vecs[i].exp_wb);
      check($sformatf("v%0d_rwe", i),   32'(rwe), 32'(vecs[i].exp_rwe));
      check($sformatf("v%0d_valid", i), 32'(valid), 32'(vecs[i].valid_in));
      check($sformatf("v%0d_rfw", i),   32'(rfw_out), 32'(vecs[i].rfw));
      check($sformatf("v%0d_rw", i),    32'(rw_out), 32'(vecs[i].rw));
      check($sformatf("v%0d_mem", i),   mem_out, vecs[i].mem);
      check($sformatf("v%0d_alu", i),   alu_out, vecs[i].alu);
      check($sformatf("v%0d_m2r", i),   32'(m2r_out), 32'(vecs[i].m2r));
    end

    // Stall holds A (including loadSize/loadSigned) while inputs move to B.
    a = '{1'b1, 32'h80FF_7F81, 32'h0000_0003, 1'b1, 2'd0, 1'b1, 4'd1, 1'b1, 32'hFFFF_FF80, 1'b1};
    b = '{1'b1, 32'h1234_5678, 32'h0000_0000, 1'b1, 2'd2, 1'b0, 4'd2, 1'b1, 32'h1234_5678, 1'b1};
    drive_vec(a);
    tick();
    check("stall_a_wb", wb_data, a.exp_wb);
    stall = 1'b1;
    drive_vec(b);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("stall%0d_wb", i),  wb_data, a.exp_wb);
      check($sformatf("stall%0d_rfw", i), 32'(rfw_out), 32'd1);
      check($sformatf("stall%0d_rwe", i), 32'(rwe), 32'd1);
    end
    stall = 1'b0;
    tick();
    check("stall_rel_wb", wb_data, b.exp_wb);
    check("stall_rel_rfw", 32'(rfw_out), 32'd2);

    // Flush beats stall.
    drive_vec(vecs[1]);
    tick();
    stall = 1'b1; flush = 1'b1;
    drive_vec(vecs[3]);
    tick();
    check_cleared("flush");
    stall = 1'b0; flush = 1'b0;

    // Reset in the middle of a stall clears; stage reloads once stall drops.
    drive_vec(vecs[4]);
    tick();
    stall = 1'b1; reset = 1'b1;
    tick();
    check_cleared("rst_stall");
    reset = 1'b0;
    tick();
    check("rst_stall_hold_valid", 32'(valid), 32'd0);
    stall = 1'b0;
    tick();
    check("rst_stall_resume_wb", wb_data, vecs[4].exp_wb);
    check("rst_stall_resume_rwe", 32'(rwe), 32'd1);

    // Retire counter: 17 valid loads, 3 stalls, 2 flushes, 2 invalid loads.
    // op 0 = valid load, 1 = stall, 2 = flush, 3 = invalid load
    ops = '{0, 0, 1, 0, 0, 3, 0, 2, 0, 0, 1, 0, 0, 0, 3, 0, 0, 2, 0, 1, 0, 0, 0, 0};
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_retire = 0;
    for (int i = 0; i < 24; i++) begin
      drive_vec(vecs[0]);
      valid_in = (ops[i] != 3);
      stall    = (ops[i] == 1);
      flush    = (ops[i] == 2);
      tick();
`ifdef MEM_WB_RETIRE_CNT_EN
      if (ops[i] == 0) exp_retire = (exp_retire + 1) % 16;
`endif
      check($sformatf("retire%0d", i), 32'(retire_cnt), 32'(exp_retire));
    end
    stall = 1'b0; flush = 1'b0;
`ifdef MEM_WB_RETIRE_CNT_EN
    check("retire_wrapped", 32'(retire_cnt), 32'd1);
`else
    check("retire_const0", 32'(retire_cnt), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
